// File: rtl/cdb_arbiter_if.sv
// Handshake and broadcast bundle between execution units, the CDB arbiter
// and the ROB/RS/LSB consumers.
interface cdb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int ADDR_W = 32
);
  logic              alu_valid;
  logic [TAG_W-1:0]  alu_tag;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              lsb_valid;
  logic [TAG_W-1:0]  lsb_tag;
  logic [DATA_W-1:0] lsb_data;
  logic              lsb_ready;

  logic              br_valid;
  logic [TAG_W-1:0]  br_tag;
  logic [DATA_W-1:0] br_data;
  logic              br_jump_judge;
  logic [ADDR_W-1:0] br_pc;
  logic              br_ready;

  logic              cdb_valid;
  logic [1:0]        cdb_src;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              cdb_jump_judge;
  logic [ADDR_W-1:0] cdb_pc;

  modport master (
    output alu_valid, alu_tag, alu_data,
    input  alu_ready,
    output lsb_valid, lsb_tag, lsb_data,
    input  lsb_ready,
    output br_valid, br_tag, br_data,
    output br_jump_judge, br_pc,
    input  br_ready,
    input  cdb_valid, cdb_src, cdb_tag,
    input  cdb_data, cdb_jump_judge, cdb_pc
  );

  modport slave (
    input  alu_valid, alu_tag, alu_data,
    output alu_ready,
    input  lsb_valid, lsb_tag, lsb_data,
    output lsb_ready,
    input  br_valid, br_tag, br_data,
    input  br_jump_judge, br_pc,
    output br_ready,
    output cdb_valid, cdb_src, cdb_tag,
    output cdb_data, cdb_jump_judge, cdb_pc
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one holding register per producer (ALU, LSB, BR),
// one registered broadcast per cycle, flushed by ROB clear.
module cdb_arbiter #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int ADDR_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         clear,
  cdb_arbiter_if.slave bus
);

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_LSB = 2'd1;
  localparam logic [1:0] SRC_BR  = 2'd2;

  logic [2:0]        r_hv;
  logic [TAG_W-1:0]  r_tag  [3];
  logic [DATA_W-1:0] r_data [3];
  logic              r_jj;
  logic [ADDR_W-1:0] r_pc;
  logic [1:0]        r_ptr;

  logic              r_cdb_valid;
  logic [1:0]        r_cdb_src;
  logic [TAG_W-1:0]  r_cdb_tag;
  logic [DATA_W-1:0] r_cdb_data;
  logic              r_cdb_jj;
  logic [ADDR_W-1:0] r_cdb_pc;

  logic [2:0]        w_vld;
  logic [TAG_W-1:0]  w_tag  [3];
  logic [DATA_W-1:0] w_data [3];
  logic [2:0]        w_gnt;
  logic [1:0]        w_win;
  logic              w_any;
  logic              w_en;
  logic [2:0]        w_rdy;
  logic [2:0]        w_xfer;

  assign w_vld  = {bus.br_valid, bus.lsb_valid, bus.alu_valid};
  assign w_tag[0]  = bus.alu_tag;
  assign w_tag[1]  = bus.lsb_tag;
  assign w_tag[2]  = bus.br_tag;
  assign w_data[0] = bus.alu_data;
  assign w_data[1] = bus.lsb_data;
  assign w_data[2] = bus.br_data;

  // First held entry in search order a, b, c as a one-hot grant.
  function automatic logic [2:0] pick(
    input logic [2:0] hv,
    input int         a,
    input int         b,
    input int         c
  );
    if (hv[a]) return 3'(1 << a);
    if (hv[b]) return 3'(1 << b);
    if (hv[c]) return 3'(1 << c);
    return 3'b000;
  endfunction

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    w_gnt = 3'b000;
    unique case (r_ptr)
      2'd0:    w_gnt = pick(r_hv, 0, 1, 2);
      2'd1:    w_gnt = pick(r_hv, 1, 2, 0);
      2'd2:    w_gnt = pick(r_hv, 2, 0, 1);
      default: w_gnt = 3'b000;
    endcase
  end

  always_comb begin
    w_win = SRC_ALU;
    unique case (1'b1)
      w_gnt[0]: w_win = SRC_ALU;
      w_gnt[1]: w_win = SRC_LSB;
      w_gnt[2]: w_win = SRC_BR;
      default:  w_win = SRC_ALU;
    endcase
  end

  assign w_any  = |w_gnt;
  assign w_en   = rdy & ~clear;
  assign w_rdy  = {3{w_en}} & (~r_hv | w_gnt);
  assign w_xfer = w_vld & w_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hv        <= 3'b000;
      r_ptr       <= 2'd0;
      r_jj        <= 1'b0;
      r_pc        <= '0;
      for (int i = 0; i < 3; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
      r_cdb_valid <= 1'b0;
      r_cdb_src   <= 2'd0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
      r_cdb_jj    <= 1'b0;
      r_cdb_pc    <= '0;
    end else if (rdy) begin
      if (clear) begin
        r_hv        <= 3'b000;
        r_ptr       <= 2'd0;
        r_cdb_valid <= 1'b0;
      end else begin
        r_hv <= w_xfer | (r_hv & ~w_gnt);
        for (int i = 0; i < 3; i++) begin
          if (w_xfer[i]) begin
            r_tag[i]  <= w_tag[i];
            r_data[i] <= w_data[i];
          end
        end
        if (w_xfer[2]) begin
          r_jj <= bus.br_jump_judge;
          r_pc <= bus.br_pc;
        end
        r_cdb_valid <= w_any;
        if (w_any) begin
          r_cdb_src  <= w_win;
          r_cdb_tag  <= r_tag[w_win];
          r_cdb_data <= r_data[w_win];
          r_cdb_jj   <= w_gnt[2] & r_jj;
          r_cdb_pc   <= w_gnt[2] ? r_pc : '0;
          r_ptr      <= nxt(w_win);
        end
      end
    end
  end

  assign bus.alu_ready      = w_rdy[0];
  assign bus.lsb_ready      = w_rdy[1];
  assign bus.br_ready       = w_rdy[2];
  assign bus.cdb_valid      = r_cdb_valid;
  assign bus.cdb_src        = r_cdb_src;
  assign bus.cdb_tag        = r_cdb_tag;
  assign bus.cdb_data       = r_cdb_data;
  assign bus.cdb_jump_judge = r_cdb_jj;
  assign bus.cdb_pc         = r_cdb_pc;

  a_ptr_range: assert property (
    @(posedge clk) disable iff (!rst) r_ptr != 2'd3
  );

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a queue-based reference model predicts
// every broadcast; a monitor pops and compares on each enabled edge.
module tb_cdb_arbiter;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic rdy   = 1'b0;
  logic clear = 1'b0;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.DATA_W(32), .TAG_W(4), .ADDR_W(32)) bus ();

  cdb_arbiter #(.DATA_W(32), .TAG_W(4), .ADDR_W(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .rdy  (rdy),
    .clear(clear),
    .bus  (bus)
  );

  typedef struct {
    int          cyc;
    logic [1:0]  src;
    logic [3:0]  tag;
    logic [31:0] data;
    logic        jj;
    logic [31:0] pc;
  } bc_t;

  bc_t q[$];
  int  ntot = 0;
  int  npass = 0;
  int  cyc = 0;

  bit          mv [3];
  logic [3:0]  mt [3];
  logic [31:0] md [3];
  logic        mjj;
  logic [31:0] mpc;
  int          mptr;
  bc_t         last;
  bit          lvalid;
  int          mon_cnt [3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    ntot++;
    if (a === e) npass++;
    else $display("FAIL %s got=%0h exp=%0h", n, a, e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) mv[i] = 0;
    mptr   = 0;
    lvalid = 0;
    last   = '{cyc: 0, src: 0, tag: 0, data: 0, jj: 0, pc: 0};
  endtask

  task automatic idle();
    bus.alu_valid = 0;
    bus.lsb_valid = 0;
    bus.br_valid  = 0;
  endtask

  task automatic offer_alu(input logic [3:0] t, input logic [31:0] d);
    bus.alu_valid = 1; bus.alu_tag = t; bus.alu_data = d;
  endtask

  task automatic offer_lsb(input logic [3:0] t, input logic [31:0] d);
    bus.lsb_valid = 1; bus.lsb_tag = t; bus.lsb_data = d;
  endtask

  task automatic offer_br(input logic [3:0] t, input logic [31:0] d,
                          input logic j, input logic [31:0] p);
    bus.br_valid = 1; bus.br_tag = t; bus.br_data = d;
    bus.br_jump_judge = j; bus.br_pc = p;
  endtask

  task automatic chk_frozen();
    chk("frz_valid", bus.cdb_valid, lvalid);
    chk("frz_src", bus.cdb_src, last.src);
    chk("frz_tag", bus.cdb_tag, last.tag);
    chk("frz_data", bus.cdb_data, last.data);
    chk("frz_jj", bus.cdb_jump_judge, last.jj);
    chk("frz_pc", bus.cdb_pc, last.pc);
  endtask

  // Called at a falling edge with inputs already applied; advances one cycle.
  task automatic step();
    int  w;
    bit  en;
    bit  er [3];
    bit  vl [3];
    bc_t e;
    #1;
    w = -1;
    for (int k = 0; k < 3; k++) begin
      int j;
      j = (mptr + k) % 3;
      if (w < 0 && mv[j]) w = j;
    end
    en = rst && rdy && !clear;
    for (int i = 0; i < 3; i++) er[i] = en && (!mv[i] || w == i);
    chk("alu_ready", bus.alu_ready, er[0]);
    chk("lsb_ready", bus.lsb_ready, er[1]);
    chk("br_ready", bus.br_ready, er[2]);
    if (!rdy) chk_frozen();
    vl[0] = bus.alu_valid;
    vl[1] = bus.lsb_valid;
    vl[2] = bus.br_valid;
    if (rst && rdy) begin
      if (clear) begin
        for (int i = 0; i < 3; i++) mv[i] = 0;
        mptr   = 0;
        lvalid = 0;
      end else begin
        if (w >= 0) begin
          e.cyc  = cyc + 1;
          e.src  = 2'(w);
          e.tag  = mt[w];
          e.data = md[w];
          e.jj   = (w == 2) ? mjj : 1'b0;
          e.pc   = (w == 2) ? mpc : 32'd0;
          q.push_back(e);
          mv[w]  = 0;
          mptr   = (w + 1) % 3;
          last   = e;
          lvalid = 1;
        end else begin
          lvalid = 0;
        end
        if (vl[0] && er[0]) begin
          mv[0] = 1; mt[0] = bus.alu_tag; md[0] = bus.alu_data;
        end
        if (vl[1] && er[1]) begin
          mv[1] = 1; mt[1] = bus.lsb_tag; md[1] = bus.lsb_data;
        end
        if (vl[2] && er[2]) begin
          mv[2] = 1; mt[2] = bus.br_tag; md[2] = bus.br_data;
          mjj = bus.br_jump_judge; mpc = bus.br_pc;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_valid"}, bus.cdb_valid, 0);
    chk({n, "_src"}, bus.cdb_src, 0);
    chk({n, "_tag"}, bus.cdb_tag, 0);
    chk({n, "_data"}, bus.cdb_data, 0);
    chk({n, "_jj"}, bus.cdb_jump_judge, 0);
    chk({n, "_pc"}, bus.cdb_pc, 0);
  endtask

  task automatic do_reset();
    #2 rst = 0;
    #1 chk_zero("rst_async");
    model_reset();
    @(negedge clk);
    rst = 1;
  endtask

  // Monitor: every enabled edge either matches the queue head or is idle.
  initial begin : monitor
    bit  act;
    bc_t e;
    forever begin
      @(posedge clk);
      act = rst && rdy && !clear;
      #1;
      if (act) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
          e = q.pop_front();
          chk("missed_bcast_cyc", cyc, e.cyc);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
          e = q.pop_front();
          chk("cdb_valid", bus.cdb_valid, 1);
          chk("cdb_src", bus.cdb_src, e.src);
          chk("cdb_tag", bus.cdb_tag, e.tag);
          chk("cdb_data", bus.cdb_data, e.data);
          chk("cdb_jj", bus.cdb_jump_judge, e.jj);
          chk("cdb_pc", bus.cdb_pc, e.pc);
          if (bus.cdb_valid) mon_cnt[bus.cdb_src]++;
        end else begin
          chk("cdb_valid_idle", bus.cdb_valid, 0);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin : stim
    bus.alu_tag = 0; bus.alu_data = 0;
    bus.lsb_tag = 0; bus.lsb_data = 0;
    bus.br_tag = 0; bus.br_data = 0;
    bus.br_jump_judge = 0; bus.br_pc = 0;
    idle();
    model_reset();
    rdy = 1;
    @(negedge clk);
    #1 chk_zero("reset_state");
    @(negedge clk);
    rst = 1;
    step();

    // single ALU result
    offer_alu(4'd5, 32'h1234);
    step();
    idle();
    repeat (3) step();

    // reset while holds are full and a broadcast is on the bus
    offer_alu(4'd8, 32'h8);
    offer_lsb(4'd9, 32'h9);
    offer_br(4'd10, 32'hA, 1'b1, 32'h40);
    step();
    step();
    chk("pre_rst_valid", bus.cdb_valid, 1);
    idle();
    do_reset();
    step();

    // three-way contention right after reset
    offer_alu(4'd1, 32'h11);
    offer_lsb(4'd2, 32'h22);
    offer_br(4'd3, 32'h33, 1'b0, 32'h0);
    step();
    idle();
    repeat (5) step();

    // ALU and LSB offering continuously
    for (int i = 0; i < 3; i++) mon_cnt[i] = 0;
    for (int i = 0; i < 20; i++) begin
      offer_alu(4'($urandom), $urandom);
      offer_lsb(4'($urandom), $urandom);
      step();
    end
    idle();
    repeat (4) step();
    chk("alt_alu_cnt", mon_cnt[0], 11);
    chk("alt_lsb_cnt", mon_cnt[1], 10);

    // branch redirect, then an ALU result with pc cleared
    offer_br(4'd7, 32'h77, 1'b1, 32'h1000);
    step();
    idle();
    step();
    offer_alu(4'd6, 32'h66);
    step();
    idle();
    repeat (3) step();

    // flush with all holds full
    offer_alu(4'd12, 32'hC);
    offer_lsb(4'd13, 32'hD);
    offer_br(4'd14, 32'hE, 1'b1, 32'h80);
    step();
    idle();
    clear = 1;
    step();
    clear = 0;
    repeat (2) step();
    offer_alu(4'd4, 32'h44);
    offer_lsb(4'd5, 32'h55);
    offer_br(4'd6, 32'h66, 1'b0, 32'h0);
    step();
    idle();
    step();
    rdy = 0;
    offer_alu(4'd9, 32'h99);
    repeat (3) step();
    idle();
    rdy = 1;
    repeat (4) step();

    // randomized traffic with stalls and flushes
    for (int i = 0; i < 400; i++) begin
      rdy   = ($urandom % 10) != 0;
      clear = ($urandom % 25) == 0;
      bus.alu_valid = $urandom % 2;
      bus.alu_tag   = 4'($urandom);
      bus.alu_data  = $urandom;
      bus.lsb_valid = $urandom % 2;
      bus.lsb_tag   = 4'($urandom);
      bus.lsb_data  = $urandom;
      bus.br_valid  = ($urandom % 3) == 0;
      bus.br_tag    = 4'($urandom);
      bus.br_data   = $urandom;
      bus.br_jump_judge = $urandom % 2;
      bus.br_pc     = $urandom;
      step();
    end
    idle();
    rdy   = 1;
    clear = 0;
    repeat (6) step();
    chk("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
